// File: rtl/usb_pkg.sv
// Shared USB transmit-path types: transmitter command codes, scheduler states
// and the default payload limit.
package usb_pkg;

    typedef enum logic [1:0] {
        TX_NONE = 2'd0,
        TX_DATA = 2'd1,
        TX_ACK  = 2'd2,
        TX_NAK  = 2'd3
    } tx_packet_t;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_DONE  = 3'd3,
        S_GAP        = 3'd4
    } sched_state_t;

    localparam int MAX_DATA_SIZE_DEF = 64;

endpackage

// File: rtl/usb_tx_sched_timer.sv
// Loadable saturating down-counter shared by the start-timeout and
// inter-packet-gap phases; o_terminal is high while the count is zero.
module usb_tx_sched_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_terminal
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_terminal = (r_count == '0);

endmodule

// File: rtl/usb_tx_scheduler.sv
// USB transmit scheduler: arbitrates handshake vs data requests, issues the
// transmitter command and enforces the inter-packet gap. USB_TX_SCHED_TOGGLE_EN
// enables internal DATA0/DATA1 toggle tracking.
module usb_tx_scheduler
    import usb_pkg::*;
#(
    parameter int START_TIMEOUT = 16,
    parameter int IPG_CYCLES    = 8,
    parameter int MAX_DATA_SIZE = MAX_DATA_SIZE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hs_req,
    input  logic       hs_type,
    output logic       hs_done,
    input  logic       data_req,
    input  logic [6:0] data_size,
    output logic       data_done,
    output logic       data_err,
    input  logic       toggle_reset,
    output logic [1:0] tx_packet,
    output logic [6:0] tx_packet_data_size,
    output logic       data_pid_odd,
    input  logic       tx_status,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int TMR_MAX = (START_TIMEOUT > IPG_CYCLES) ? START_TIMEOUT : IPG_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    // The counter is zero on the last cycle of a phase, so load one less.
    localparam logic [TMR_W-1:0] START_LOAD = TMR_W'(START_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(IPG_CYCLES - 1);

    sched_state_t r_state, w_next_state;
    tx_packet_t   w_pkt;
    logic         r_is_data;
    logic         r_hs_nak;
    logic [6:0]   r_size;
    logic         r_hs_done;
    logic         r_data_done;
    logic         r_data_err;
    logic         r_pid_odd;
    logic         w_size_ok;
    logic         w_grant_hs;
    logic         w_grant_data;
    logic         w_reject;
    logic         w_tx_fall;
    logic         w_timeout;
    logic         w_tmr_clear;
    logic         w_tmr_load;
    logic         w_tmr_en;
    logic         w_tmr_term;
    logic [TMR_W-1:0] w_tmr_load_val;

    assign w_size_ok    = (int'(data_size) <= MAX_DATA_SIZE);
    assign w_grant_hs   = (r_state == S_IDLE) && hs_req;
    // r_data_err blocks the request that is still held during the error pulse.
    assign w_grant_data = (r_state == S_IDLE) && !hs_req && data_req && !r_data_err && w_size_ok;
    assign w_reject     = (r_state == S_IDLE) && !hs_req && data_req && !r_data_err && !w_size_ok;
    assign w_tx_fall    = (r_state == S_WAIT_DONE) && !tx_status;
    assign w_timeout    = (r_state == S_WAIT_START) && !tx_status && w_tmr_term;

    assign w_tmr_clear    = (r_state == S_IDLE);
    assign w_tmr_load     = (r_state == S_ISSUE) || w_tx_fall || w_timeout;
    assign w_tmr_load_val = (r_state == S_ISSUE) ? START_LOAD : GAP_LOAD;
    assign w_tmr_en       = (r_state == S_WAIT_START) || (r_state == S_GAP);

    usb_tx_sched_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_tmr_clear),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_load_val),
        .i_en       (w_tmr_en),
        .o_terminal (w_tmr_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:       if (w_grant_hs || w_grant_data) w_next_state = S_ISSUE;
            S_ISSUE:      w_next_state = S_WAIT_START;
            S_WAIT_START: begin
                if (tx_status) w_next_state = S_WAIT_DONE;
                else if (w_tmr_term) w_next_state = S_GAP;
            end
            S_WAIT_DONE:  if (!tx_status) w_next_state = S_GAP;
            S_GAP:        if (w_tmr_term) w_next_state = S_IDLE;
            default:      w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_pkt = TX_NONE;
        if (r_state == S_ISSUE) begin
            if (r_is_data) w_pkt = TX_DATA;
            else if (r_hs_nak) w_pkt = TX_NAK;
            else w_pkt = TX_ACK;
        end
    end

    assign tx_packet           = w_pkt;
    assign busy                = (r_state != S_IDLE);
    assign dbg_state           = r_state;
    assign tx_packet_data_size = ((r_state != S_IDLE) && r_is_data) ? r_size : 7'd0;
    assign data_pid_odd        = ((r_state != S_IDLE) && r_is_data) ? r_pid_odd : 1'b0;
    assign hs_done             = r_hs_done;
    assign data_done           = r_data_done;
    assign data_err            = r_data_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_is_data <= 1'b0;
            r_hs_nak  <= 1'b0;
            r_size    <= 7'd0;
        end else if (w_grant_hs) begin
            r_is_data <= 1'b0;
            r_hs_nak  <= hs_type;
            r_size    <= 7'd0;
        end else if (w_grant_data) begin
            r_is_data <= 1'b1;
            r_hs_nak  <= 1'b0;
            r_size    <= data_size;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hs_done   <= 1'b0;
            r_data_done <= 1'b0;
            r_data_err  <= 1'b0;
        end else begin
            r_hs_done   <= (w_tx_fall || w_timeout) && !r_is_data;
            r_data_done <= w_tx_fall && r_is_data;
            r_data_err  <= w_reject || (w_timeout && r_is_data);
        end
    end

`ifdef USB_TX_SCHED_TOGGLE_EN
    logic r_toggle;

    // toggle_reset beats a coincident completion flip.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_toggle <= 1'b0;
        end else if (toggle_reset) begin
            r_toggle <= 1'b0;
        end else if (w_tx_fall && r_is_data) begin
            r_toggle <= ~r_toggle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pid_odd <= 1'b0;
        end else if (w_grant_data) begin
            r_pid_odd <= r_toggle;
        end
    end
`else
    logic w_unused_toggle_reset;

    assign w_unused_toggle_reset = toggle_reset;
    assign r_pid_odd             = 1'b0;
`endif

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Self-checking bench for usb_tx_scheduler; issued packets are checked against
// an expected queue, pulse timing against fixed cycle counts.
module tb_usb_tx_scheduler;

    localparam int START_TIMEOUT = 16;
    localparam int IPG_CYCLES    = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       hs_req = 1'b0;
    logic       hs_type = 1'b0;
    logic       hs_done;
    logic       data_req = 1'b0;
    logic [6:0] data_size = 7'd0;
    logic       data_done;
    logic       data_err;
    logic       toggle_reset = 1'b0;
    logic [1:0] tx_packet;
    logic [6:0] tx_packet_data_size;
    logic       data_pid_odd;
    logic       tx_status = 1'b0;
    logic       busy;
    logic [2:0] dbg_state;

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_e;
    logic [1:0] prev_pkt = 2'd0;
    logic       m_toggle = 1'b0;

    usb_tx_scheduler #(
        .START_TIMEOUT (START_TIMEOUT),
        .IPG_CYCLES    (IPG_CYCLES),
        .MAX_DATA_SIZE (64)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .hs_req              (hs_req),
        .hs_type             (hs_type),
        .hs_done             (hs_done),
        .data_req            (data_req),
        .data_size           (data_size),
        .data_done           (data_done),
        .data_err            (data_err),
        .toggle_reset        (toggle_reset),
        .tx_packet           (tx_packet),
        .tx_packet_data_size (tx_packet_data_size),
        .data_pid_odd        (data_pid_odd),
        .tx_status           (tx_status),
        .busy                (busy),
        .dbg_state           (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_pid();
`ifdef USB_TX_SCHED_TOGGLE_EN
        return m_toggle;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic sig(input int sel);
        case (sel)
            0:       return tx_packet != 2'd0;
            1:       return hs_done;
            2:       return data_done;
            3:       return data_err;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_for(input string tag, input int sel, input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(sel) && n < limit);
        check(tag, 32'(sig(sel)), 1);
    endtask

    // Scoreboard: every issued command is matched against the expected queue.
    always @(negedge clk) begin
        if (!rst && tx_packet != 2'd0) begin
            check("pkt_1cyc", 32'(prev_pkt), 0);
            if (exp_q.size() == 0) begin
                check("pkt_unexp", 32'(tx_packet), 0);
            end else begin
                exp_e = exp_q.pop_front();
                check("pkt", {22'd0, tx_packet, tx_packet_data_size, data_pid_odd}, {22'd0, exp_e});
            end
        end
        prev_pkt = tx_packet;
    end

    task automatic run_tx(input int sdly, input int blen);
        repeat (sdly) @(negedge clk);
        tx_status = 1'b1;
        repeat (blen) @(negedge clk);
    endtask

    task automatic send_data(input int size, input int sdly, input int blen, input bit tr_done,
                             input string tag);
        int n;
        exp_q.push_back({2'd1, 7'(size), exp_pid()});
        @(negedge clk);
        data_req  = 1'b1;
        data_size = 7'(size);
        wait_for({tag, "_pkt"}, 0, 8, n);
        check({tag, "_lat"}, n, 1);
        run_tx(sdly, blen);
        check({tag, "_size_held"}, 32'(tx_packet_data_size), size);
        tx_status = 1'b0;
        if (tr_done) toggle_reset = 1'b1;
        wait_for({tag, "_done"}, 2, 6, n);
        check({tag, "_done_lat"}, n, 1);
        toggle_reset = 1'b0;
        data_req     = 1'b0;
        m_toggle     = tr_done ? 1'b0 : ~m_toggle;
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(data_done), 0);
        wait_for({tag, "_idle"}, 4, 20, n);
    endtask

    task automatic send_hs(input bit typ, input int sdly, input int blen, input string tag);
        int n;
        exp_q.push_back({typ ? 2'd3 : 2'd2, 7'd0, 1'b0});
        @(negedge clk);
        hs_req  = 1'b1;
        hs_type = typ;
        wait_for({tag, "_pkt"}, 0, 8, n);
        check({tag, "_lat"}, n, 1);
        hs_type = ~typ;
        run_tx(sdly, blen);
        tx_status = 1'b0;
        wait_for({tag, "_done"}, 1, 6, n);
        check({tag, "_done_lat"}, n, 1);
        hs_req  = 1'b0;
        hs_type = 1'b0;
        wait_for({tag, "_idle"}, 4, 20, n);
    endtask

    initial begin
        int  n;
        logic seen;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_pkt", 32'(tx_packet), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_dones", {29'd0, hs_done, data_done, data_err}, 0);
        check("rst_size", 32'(tx_packet_data_size), 0);
        check("rst_pid", 32'(data_pid_odd), 0);
        check("rst_state", 32'(dbg_state), 0);

        send_data(12, 3, 20, 1'b0, "d12");
        send_data(5, 2, 4, 1'b0, "d5");

        // Oversize request: error pulse while staying idle.
        @(negedge clk);
        data_req  = 1'b1;
        data_size = 7'd65;
        @(negedge clk);
        check("rej_err", 32'(data_err), 1);
        check("rej_busy", 32'(busy), 0);
        check("rej_pkt", 32'(tx_packet), 0);
        @(negedge clk);
        check("rej_err_1cyc", 32'(data_err), 0);
        data_req = 1'b0;
        @(negedge clk);
        check("rej_idle", 32'(busy), 0);

        // Transmitter never starts.
        exp_q.push_back({2'd1, 7'd40, exp_pid()});
        @(negedge clk);
        data_req  = 1'b1;
        data_size = 7'd40;
        wait_for("to_pkt", 0, 8, n);
        wait_for("to_err", 3, 40, n);
        check("to_err_lat", n, START_TIMEOUT + 1);
        data_req = 1'b0;
        check("to_busy_gap", 32'(busy), 1);
        wait_for("to_idle", 4, 20, n);
        check("to_gap_len", n, IPG_CYCLES);

        // Simultaneous requests: handshake first, data after the gap.
        exp_q.push_back({2'd3, 7'd0, 1'b0});
        exp_q.push_back({2'd1, 7'd20, exp_pid()});
        @(negedge clk);
        hs_req    = 1'b1;
        hs_type   = 1'b1;
        data_req  = 1'b1;
        data_size = 7'd20;
        wait_for("both_hs_pkt", 0, 8, n);
        check("both_hs_lat", n, 1);
        run_tx(2, 5);
        tx_status = 1'b0;
        wait_for("both_hs_done", 1, 6, n);
        hs_req  = 1'b0;
        hs_type = 1'b0;
        wait_for("both_data_pkt", 0, 30, n);
        check("both_ipg", n, IPG_CYCLES + 1);
        run_tx(2, 6);
        tx_status = 1'b0;
        wait_for("both_data_done", 2, 6, n);
        data_req = 1'b0;
        m_toggle = ~m_toggle;
        wait_for("both_idle", 4, 20, n);

        // Toggle reset while idle, then coincident with a completion.
        @(negedge clk);
        toggle_reset = 1'b1;
        @(negedge clk);
        toggle_reset = 1'b0;
        m_toggle     = 1'b0;
        send_data(33, 1, 3, 1'b0, "tr_idle");
        send_data(7, 1, 3, 1'b0, "tr_pre");
        send_data(9, 2, 2, 1'b1, "tr_coinc");
        send_data(64, 1, 5, 1'b0, "tr_after");

        send_hs(1'b0, 3, 4, "ack");
        send_data(0, 1, 2, 1'b0, "zero");

        // Reset while the transmitter is busy.
        exp_q.push_back({2'd1, 7'd30, exp_pid()});
        @(negedge clk);
        data_req  = 1'b1;
        data_size = 7'd30;
        wait_for("rw_pkt", 0, 8, n);
        run_tx(1, 3);
        check("rw_size_held", 32'(tx_packet_data_size), 30);
        check("rw_pid_held", 32'(data_pid_odd), 32'(exp_pid()));
        #2 rst = 1'b1;
        #1;
        check("rw_busy", 32'(busy), 0);
        check("rw_outs", {22'd0, tx_packet, tx_packet_data_size, data_pid_odd}, 0);
        data_req  = 1'b0;
        tx_status = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        m_toggle = 1'b0;
        seen     = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | data_done | hs_done | data_err | busy;
        end
        check("rw_quiet", 32'(seen), 0);
        send_data(17, 2, 3, 1'b0, "rw_after");

        for (int i = 0; i < 4; i++) begin
            send_data(int'($urandom_range(0, 64)), int'($urandom_range(1, 6)),
                      int'($urandom_range(1, 10)), 1'b0, "rnd");
        end

        repeat (3) @(negedge clk);
        check("q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_tx_scheduler.md
Name: usb_tx_scheduler

Overview:
- Sequences the USB transmit path: arbitrates between the handshake requester (RX-side protocol logic needing ACK/NAK) and the data requester (AHB-side buffer with a DATA packet ready).
- Drives the transmitter's packet-type/size command and tracks transmitter completion.
- Enforces the inter-packet gap and maintains the DATA0/DATA1 toggle.
- Sits between the protocol/AHB logic and the TX top level.

Parameters:
- START_TIMEOUT, 16, cycles allowed between command issue and tx_status rising before the request is abandoned.
- IPG_CYCLES, 8, idle cycles enforced after tx_status falls before the next command.
- MAX_DATA_SIZE, 64, largest legal data payload in bytes.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- hs_req  in  1  handshake request; level, held until hs_done.
- hs_type  in  1  0 = ACK, 1 = NAK; sampled at grant.
- hs_done  out  1  one-cycle pulse, handshake transmission finished.
- data_req  in  1  data packet request; level, held until data_done or data_err.
- data_size  in  7  payload bytes, 0..MAX_DATA_SIZE; sampled at grant.
- data_done  out  1  one-cycle pulse, data packet finished.
- data_err  out  1  one-cycle pulse, data request rejected (size) or start timeout.
- toggle_reset  in  1  forces next DATA PID to DATA0 (SETUP received).
- tx_packet  out  2  command to transmitter: 0 none, 1 DATA, 2 ACK, 3 NAK; nonzero for exactly one cycle.
- tx_packet_data_size  out  7  payload size, valid and held from issue until done.
- data_pid_odd  out  1  0 = DATA0, 1 = DATA1, held with tx_packet_data_size.
- tx_status  in  1  transmitter busy (high from first SYNC bit through EOP).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0; state IDLE; toggle 0; counters 0. Reset mid-packet returns to IDLE immediately; no done pulse is generated.
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, GAP.
- IDLE:
  - hs_req has fixed priority over data_req.
  - Grant latches the requester, hs_type or data_size, and the current toggle, then moves to ISSUE.
  - Data grant with data_size > MAX_DATA_SIZE: pulse data_err next cycle, stay IDLE, no tx_packet.
  - Both requests in the same cycle: handshake wins; data waits.
- ISSUE: drive tx_packet code for one cycle, clear the timer, go to WAIT_START.
- WAIT_START:
  - tx_status = 1: go to WAIT_DONE.
  - START_TIMEOUT cycles elapse: pulse data_err (data) or hs_done (handshake abandoned), go to GAP.
- WAIT_DONE: on tx_status = 0, pulse the requester's done in the next cycle and go to GAP.
  - Data only: toggle flips on completion.
- GAP: count IPG_CYCLES cycles, then go to IDLE. Requests arriving during GAP wait.
- Latency: request seen in IDLE at cycle N; tx_packet nonzero at N+1.
- toggle_reset:
  - Any time: toggle becomes 0 next cycle.
  - If asserted in the same cycle as a data completion: reset wins, toggle = 0.
  - Does not alter the latched data_pid_odd of an in-flight packet.
- Zero-length data (data_size = 0) is legal and sent as a DATA packet with size 0.
- Timer width: clog2(max(START_TIMEOUT, IPG_CYCLES)) + 1 bits. Never wraps; saturates at its terminal count.

Optional Feature:
- Macro: USB_TX_SCHED_TOGGLE_EN.
- Defined: internal toggle tracking as above.
- Not defined:
  - data_pid_odd is tied 0 and toggle_reset is ignored; the toggle register is not built.
  - Every data packet is sent as DATA0; the upstream block owns the toggle.

Decomposition:
- Shared package usb_pkg:
  - tx_packet_t enum (TX_NONE = 0, TX_DATA = 1, TX_ACK = 2, TX_NAK = 3).
  - Scheduler state enum.
  - MAX_DATA_SIZE default constant.
- One sub-module: usb_tx_sched_timer, a loadable saturating down-counter shared by the timeout and gap phases (clear, load value, enable, terminal flag).
- Arbitration and FSM stay in the top module.

Test Plan:
- data_req = 1, data_size = 12, tx_status high 3 cycles after issue, low 20 cycles later -> tx_packet = 1 for one cycle, size 12, pid_odd 0, data_done one pulse, next data gets pid_odd 1.
- hs_req and data_req asserted same cycle (hs_type = 1) -> tx_packet = 3 first; DATA issued exactly IPG_CYCLES + 1 cycles after hs_done, not earlier.
- data_size = 65 -> data_err pulse, tx_packet stays 0, busy stays 0, toggle unchanged.
- tx_status never rises after issue -> data_err after 16 cycles in WAIT_START, then GAP, then IDLE; toggle unchanged.
- Two data packets completed, then toggle_reset pulse -> third packet pid_odd 0; toggle_reset coincident with completion -> toggle 0.
- rst asserted in WAIT_DONE -> all outputs 0 asynchronously, no done pulse; a new request after release is serviced normally with pid_odd 0.
